// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request sequencer: opcode encodings
// (identical to the ALU's), FSM state type and opcode classification helpers.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_ANOT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_ANOT};
    endfunction

    // Only ADD/SUB produce a meaningful carry; the ALU leaves CF stale otherwise.
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_req_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids and a
// last-granted pointer that moves to the granted requester on accept.
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    logic ptr_q;

    assign gnt_valid_o = valid0_i || valid1_i;
    // On a tie the requester that was not granted last wins.
    assign gnt_id_o    = (valid0_i && valid1_i) ? ~ptr_q : valid1_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= 1'b1;
        end else if (accept_i) begin
            ptr_q <= gnt_id_o;
        end
    end

endmodule

// File: rtl/alu_req_sequencer.sv
// Sequences operations from two requesters onto the shared ALU and returns
// the captured result/flags on a single response channel tagged with the ID.
module alu_req_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [3:0]       REQ0_OPCODE,
    input  logic [Width-1:0] REQ0_A,
    input  logic [Width-1:0] REQ0_B,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [3:0]       REQ1_OPCODE,
    input  logic [Width-1:0] REQ1_A,
    input  logic [Width-1:0] REQ1_B,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic [Width-1:0] RSP_RESULT,
    output logic             RSP_CF,
    output logic             RSP_OF,
    output logic             RSP_SF,
    output logic             RSP_ZF,
    output logic             RSP_ERR,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [Width-1:0] ALU_A,
    output logic [Width-1:0] ALU_B,
    input  logic [Width-1:0] ALU_OUT,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF,
    output state_t           DBG_STATE
);

    // Handshakes: a transfer happens on the rising edge where VALID && READY;
    // the source holds its fields stable while VALID && !READY.

    state_t             state_q;
    logic [3:0]         op_q;
    logic [Width-1:0]   a_q, b_q;
    logic               id_q;
    logic               alu_en_q, alu_oe_q;
    logic               rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [Width-1:0]   rsp_result_q;
    logic               rsp_cf_q, rsp_of_q, rsp_sf_q, rsp_zf_q;

    logic               gnt_valid, gnt_id, accept;
    logic [3:0]         sel_op;
    logic [Width-1:0]   sel_a, sel_b;

    rr_arb2 u_arb (
        .clk_i      (CLK),
        .rst_n_i    (RST_N),
        .valid0_i   (REQ0_VALID),
        .valid1_i   (REQ1_VALID),
        .accept_i   (accept),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    assign accept     = (state_q == IDLE) && gnt_valid;
    assign REQ0_READY = accept && !gnt_id;
    assign REQ1_READY = accept && gnt_id;

    always_comb begin
        sel_op = gnt_id ? REQ1_OPCODE : REQ0_OPCODE;
        sel_a  = gnt_id ? REQ1_A      : REQ0_A;
        sel_b  = gnt_id ? REQ1_B      : REQ0_B;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_oe_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_cf_q     <= 1'b0;
            rsp_of_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
            rsp_zf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= sel_op;
                        a_q  <= sel_a;
                        b_q  <= sel_b;
                        id_q <= gnt_id;
                        if (is_legal_op(sel_op)) begin
                            state_q  <= EXEC;
                            alu_en_q <= 1'b1;
                        end else begin
                            // Illegal opcode never reaches the ALU.
                            state_q      <= RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_id_q     <= gnt_id;
                            rsp_err_q    <= 1'b1;
                            rsp_result_q <= '0;
                            rsp_cf_q     <= 1'b0;
                            rsp_of_q     <= 1'b0;
                            rsp_sf_q     <= 1'b0;
                            rsp_zf_q     <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    state_q  <= CAPT;
                    alu_en_q <= 1'b0;
                    alu_oe_q <= 1'b1;
                end
                CAPT: begin
                    state_q      <= RESP;
                    alu_oe_q     <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= id_q;
                    rsp_err_q    <= 1'b0;
                    rsp_result_q <= ALU_OUT;
                    rsp_cf_q     <= is_arith_op(op_q) ? ALU_CF : 1'b0;
                    rsp_of_q     <= ALU_OF;
                    rsp_sf_q     <= ALU_SF;
                    rsp_zf_q     <= ALU_ZF;
                end
                RESP: begin
                    if (RSP_READY) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ALU_EN     = alu_en_q;
    assign ALU_OE     = alu_oe_q;
    assign ALU_OPCODE = op_q;
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ID     = rsp_id_q;
    assign RSP_RESULT = rsp_result_q;
    assign RSP_CF     = rsp_cf_q;
    assign RSP_OF     = rsp_of_q;
    assign RSP_SF     = rsp_sf_q;
    assign RSP_ZF     = rsp_zf_q;
    assign RSP_ERR    = rsp_err_q;
    assign DBG_STATE  = state_q;

endmodule
